// File: rtl/adder_word_sequencer.sv
// Wide two's-complement add/subtract built by stepping one shared 4-bit adder
// over NSLICE nibbles, least significant first, with the carry held in a register.
module adder_word_sequencer #(
  parameter int NSLICE = 4,
  localparam int W = 4 * NSLICE
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         carry_out,
  output logic         overflow
);

  localparam int IW = $clog2(NSLICE);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, result_q, result_d;
  logic          cy_q, cy_d, carry_q, carry_d, ovf_q, ovf_d;

  logic [3:0]    add_x, add_y, add_sum;
  logic          add_cin, add_cout;
  logic          last_slice;

  assign last_slice = (idx_q == IW'(NSLICE - 1));

  // The shared adder sees zeros outside RUN so nothing undefined leaks through it.
  always_comb begin
    add_x   = '0;
    add_y   = '0;
    add_cin = 1'b0;
    if (state_q == RUN) begin
      add_x   = a_q[{idx_q, 2'b00} +: 4];
      add_y   = b_q[{idx_q, 2'b00} +: 4];
      add_cin = cy_q;
    end
  end

  twos_complement_adder u_adder (
    .x    (add_x),
    .y    (add_y),
    .c_in (add_cin),
    .sum  (add_sum),
    .c_out(add_cout)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    cy_d     = cy_q;
    result_d = result_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          // Subtraction is a + ~b + 1: invert B once and seed the carry with 1.
          a_d      = a;
          b_d      = sub ? ~b : b;
          cy_d     = sub;
          idx_d    = '0;
          result_d = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        result_d[{idx_q, 2'b00} +: 4] = add_sum;
        cy_d  = add_cout;
        idx_d = idx_q + IW'(1);
        if (last_slice) begin
          carry_d = add_cout;
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (add_sum[3] != a_q[W-1]);
          idx_d   = '0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cy_q     <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cy_q     <= cy_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign result    = result_q;
  assign carry_out = carry_q;
  assign overflow  = ovf_q;

endmodule

// 4-bit adder slice with carry in/out; reused every cycle by the sequencer.
module twos_complement_adder (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out
);

  logic [4:0] full;

  assign full  = {1'b0, x} + {1'b0, y} + {4'b0000, c_in};
  assign sum   = full[3:0];
  assign c_out = full[4];

endmodule

// File: tb/tb_adder_word_sequencer.sv
// Bench for adder_word_sequencer: directed vectors plus a cycle-level reference model.
module tb_adder_word_sequencer;

  localparam int NS = 4;
  localparam int W  = 4 * NS;

  logic         clk = 1'b0;
  logic         rst_n, start, sub;
  logic [W-1:0] a, b;
  logic         busy, done, carry_out, overflow;
  logic [W-1:0] result;

  int checks   = 0;
  int failures = 0;

  adder_word_sequencer #(.NSLICE(NS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .carry_out(carry_out),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic logic [W-1:0] f_res(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic s);
    return s ? x - y : x + y;
  endfunction

  function automatic logic f_carry(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic s);
    longint ux, uy;
    ux = longint'(x);
    uy = longint'(y);
    if (s) return ux >= uy;
    return (ux + uy) >= (longint'(1) << W);
  endfunction

  function automatic logic f_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic s);
    longint sx, sy, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r  = s ? sx - sy : sx + sy;
    return (r > (longint'(1) << (W - 1)) - 1) || (r < -(longint'(1) << (W - 1)));
  endfunction

  // Reference: an accepted op keeps the unit busy NS cycles, then done for one cycle.
  int           m_cnt;
  logic         m_done, m_c, m_v, p_c, p_v;
  logic [W-1:0] m_res, p_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt  <= 0;
      m_done <= 1'b0;
      m_res  <= '0;
      m_c    <= 1'b0;
      m_v    <= 1'b0;
      p_res  <= '0;
      p_c    <= 1'b0;
      p_v    <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_cnt == 0) begin
        if (start) begin
          m_cnt <= NS;
          m_res <= '0;
          p_res <= f_res(a, b, sub);
          p_c   <= f_carry(a, b, sub);
          p_v   <= f_ovf(a, b, sub);
        end
      end else begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_done <= 1'b1;
          m_res  <= p_res;
          m_c    <= p_c;
          m_v    <= p_v;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #1;
      chk("busy", 32'(busy), 32'(m_cnt > 0));
      chk("done", 32'(done), 32'(m_done));
      if (m_cnt == 0) begin
        chk("result", 32'(result), 32'(m_res));
        chk("carry_out", 32'(carry_out), 32'(m_c));
        chk("overflow", 32'(overflow), 32'(m_v));
      end
    end
  end

  task automatic wait_done(output int k);
    k = 1;
    while (!done && k < 30) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("done_seen", 32'(done), 32'd1);
  endtask

  task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts,
                    input logic [W-1:0] er, input logic ec, input logic ev);
    int k;
    @(negedge clk);
    a = ta; b = tb; sub = ts; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    wait_done(k);
    chk("latency", 32'(k), 32'(NS + 1));
    chk("lit_result", 32'(result), 32'(er));
    chk("lit_carry", 32'(carry_out), 32'(ec));
    chk("lit_ovf", 32'(overflow), 32'(ev));
    chk("model_result", 32'(m_res), 32'(er));
    chk("model_carry", 32'(m_c), 32'(ec));
    chk("model_ovf", 32'(m_v), 32'(ev));
  endtask

  initial begin
    int k;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_carry", 32'(carry_out), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    op(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
    op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    op(16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b1, 1'b0);
    op(16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // A second start while busy must be dropped.
    @(negedge clk);
    a = 16'h0001; b = 16'h0001; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 16'hAAAA; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    wait_done(k);
    chk("ignored_latency", 32'(k), 32'd3);
    chk("ignored_result", 32'(result), 32'h0002);
    // Start during the done cycle is taken immediately.
    a = 16'h0100; b = 16'h0011; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("single_done", 32'(done), 32'd0);
    wait_done(k);
    chk("done_to_done", 32'(k), 32'(NS + 1));
    chk("chained_result", 32'(result), 32'h0111);

    // Asynchronous reset after two slices aborts silently.
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_carry", 32'(carry_out), 32'd0);
    chk("abort_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      chk("abort_no_done", 32'(done), 32'd0);
    end
    op(16'h0010, 16'h0020, 1'b0, 16'h0030, 1'b0, 1'b0);

    // Dense random traffic, including starts while busy.
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) != 0);
      a     = W'($urandom);
      b     = W'($urandom);
      sub   = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    start = 1'b0;
    repeat (2 * NS + 4) @(negedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
